alu_rr_multicycle: RTL

ALU_RR_MULTICYCLE -- requirements
Module: alu_rr_multicycle

---
 rtl/alu_rr_multicycle_if.sv | 27 ++
 rtl/alu_rr_multicycle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_multicycle_if.sv
// Request/response bundle for the register-register ALU.
// master drives the request; slave returns result, busy, illegal.
interface alu_rr_multicycle_if #(
  parameter int XLEN = 32
);
  logic            alu_enable;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] rd_value;
  logic            rd_valid;
  logic            busy;
  logic            illegal;

  modport master (
    output alu_enable, funct3, funct7,
    output rs1_value, rs2_value,
    input  rd_value, rd_valid, busy, illegal
  );

  modport slave (
    input  alu_enable, funct3, funct7,
    input  rs1_value, rs2_value,
    output rd_value, rd_valid, busy, illegal
  );
endinterface

// File: rtl/alu_rr_multicycle.sv
// RV32 OP-class ALU: single-cycle base ops, optional iterative M ops.
// Ports: clock, reset (async, active-high), bus (slave modport).
// bus: alu_enable/funct3/funct7/rs1_value/rs2_value in;
//      rd_value/rd_valid/busy/illegal out.
// Macro ALU_RR_M_EXT_EN enables MUL/DIV (funct7=0000001);
// without it those encodings are reported illegal and busy is 0.
module alu_rr_multicycle #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clock,
  input  logic               reset,
  alu_rr_multicycle_if.slave bus
);
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    base_res;
  logic               base_ok;
  logic               accept;
  logic               busy_q;
  logic [XLEN-1:0]    rd_value_q;
  logic               rd_valid_q;
  logic               illegal_q;

  assign a      = bus.rs1_value;
  assign b      = bus.rs2_value;
  assign shamt  = bus.rs2_value[SHAMT_W-1:0];
  assign accept = bus.alu_enable & ~busy_q;

  assign bus.rd_value = rd_value_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.illegal  = illegal_q;

  always_comb begin
    base_res = '0;
    base_ok  = 1'b0;
    unique case (1'b1)
      (bus.funct7 == F7_BASE): begin
        base_ok = 1'b1;
        unique case (bus.funct3)
          3'b000: base_res = a + b;
          3'b001: base_res = a << shamt;
          3'b010: base_res = {{(XLEN-1){1'b0}},
                              $signed(a) < $signed(b)};
          3'b011: base_res = {{(XLEN-1){1'b0}}, a < b};
          3'b100: base_res = a ^ b;
          3'b101: base_res = a >> shamt;
          3'b110: base_res = a | b;
          3'b111: base_res = a & b;
        endcase
      end
      (bus.funct7 == F7_ALT): begin
        unique case (bus.funct3)
          3'b000: begin
            base_ok  = 1'b1;
            base_res = a - b;
          end
          3'b101: begin
            base_ok  = 1'b1;
            base_res = $signed(a) >>> shamt;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef ALU_RR_M_EXT_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_FIXUP = 2'd3;
  localparam int         CW      = $clog2(XLEN + 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        m_f3;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic              m_op;
  logic              a_sgn;
  logic              b_sgn;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a_c;
  logic [XLEN-1:0]   mag_b_c;
  logic [XLEN:0]     mul_hi;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rw;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign m_op  = bus.funct7 == F7_MEXT;
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU not rs2.
  assign a_sgn = (m_f3 == 3'b001) | (m_f3 == 3'b010) |
                 (m_f3 == 3'b100) | (m_f3 == 3'b110);
  assign b_sgn = (m_f3 == 3'b001) | (m_f3 == 3'b100) |
                 (m_f3 == 3'b110);
  assign neg_a = a_sgn & op_a[XLEN-1];
  assign neg_b = b_sgn & op_b[XLEN-1];

  assign mag_a_c = neg_a ? -op_a : op_a;
  assign mag_b_c = neg_b ? -op_b : op_b;

  // acc = {hi, multiplier}; add on lsb, then shift right.
  assign mul_hi   = acc[0]
                  ? {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_b}
                  : {1'b0, acc[2*XLEN-1:XLEN]};
  assign mul_next = {mul_hi, acc[XLEN-1:1]};

  // acc = {rem, quo}; restoring step, borrow in the top bit.
  assign div_rw   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_rw - {1'b0, mag_b};
  assign div_next = div_diff[XLEN]
                  ? {div_rw[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_b == '0) begin
      quo = '1;
      rem = op_a;
    end
    fix_res = '0;
    unique case (m_f3)
      3'b000:  fix_res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  fix_res = quo;
      default: fix_res = rem;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      m_f3       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mag_b      <= '0;
      acc        <= '0;
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && m_op) begin
            state  <= bus.funct3[2] ? S_DIV : S_MUL;
            busy_q <= 1'b1;
            cnt    <= '0;
            m_f3   <= bus.funct3;
            op_a   <= a;
            op_b   <= b;
          end else if (accept) begin
            rd_valid_q <= 1'b1;
            illegal_q  <= ~base_ok;
            rd_value_q <= base_ok ? base_res : '0;
          end
        end
        S_MUL, S_DIV: begin
          // cnt 0 loads magnitudes; cnt 1..XLEN iterate.
          if (cnt == '0) begin
            acc   <= {{XLEN{1'b0}}, mag_a_c};
            mag_b <= mag_b_c;
          end else if (state == S_MUL) begin
            acc <= mul_next;
          end else begin
            acc <= div_next;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          state      <= S_IDLE;
          cnt        <= '0;
          busy_q     <= 1'b0;
          rd_valid_q <= 1'b1;
          rd_value_q <= fix_res;
        end
      endcase
    end
  end
`else
  assign busy_q = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (accept) begin
        rd_valid_q <= 1'b1;
        illegal_q  <= ~base_ok;
        rd_value_q <= base_ok ? base_res : '0;
      end
    end
  end
`endif
endmodule
